// File: rtl/norz_seq_pkg.sv
// Shared types and constants for the NORZ machine-cycle sequencer.
package norz_seq_pkg;

  typedef enum logic [3:0] {
    ST_RST   = 4'd0,
    ST_M1_T1 = 4'd1,
    ST_M1_T2 = 4'd2,
    ST_M1_T3 = 4'd3,
    ST_M1_T4 = 4'd4,
    ST_MR_T1 = 4'd5,
    ST_MR_T2 = 4'd6,
    ST_MR_T3 = 4'd7,
    ST_DEC   = 4'd8
  } seq_state_e;

  localparam logic [7:0] ITABLE_RESET = 8'h00;
  localparam int         XPT_WIDTH    = 4;

endpackage

// File: rtl/norz_xpt_counter.sv
// Saturating execution-phase counter with synchronous clear and true/complement outputs.
module norz_xpt_counter
  import norz_seq_pkg::*;
#(
  parameter int unsigned MAX = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [XPT_WIDTH-1:0] cnt_o,
  output logic [XPT_WIDTH-1:0] cnt_n_o
);

  localparam logic [XPT_WIDTH-1:0] MAX_V = XPT_WIDTH'(MAX);

  logic [XPT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_n_o = ~cnt_q;

endmodule

// File: rtl/norz_cycle_sequencer.sv
// Z80-style M1/MR bus-cycle sequencer feeding opcode (ITABLE) and phase (XPT) state
// to the NORZ decoder tree; all outputs are decoded from registers only.
module norz_cycle_sequencer
  import norz_seq_pkg::*;
#(
  parameter bit          RFSH_EN = 1'b1,
  parameter int unsigned XPT_MAX = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           DataIn,
  input  logic                 notWAIT,
  input  logic                 P2_Set_CM1,
  input  logic                 P2_Set_CMR,
  input  logic                 P2_Reset_ITABLE,
  input  logic                 PR_Reset_XPT,
  output logic [7:0]           ITABLE,
  output logic [7:0]           notITABLE,
  output logic [XPT_WIDTH-1:0] XPT,
  output logic [XPT_WIDTH-1:0] notXPT,
  output logic                 decode_enable,
  output logic                 MREQ,
  output logic                 RD,
  output logic                 M1,
  output logic                 RFSH,
  output logic                 addr_sel_r,
  output logic [6:0]           R,
  output logic                 pc_inc,
  output logic [7:0]           ReadData,
  output logic                 data_valid
);

  seq_state_e state_q, state_d;
  logic [7:0] itable_q, itable_d;
  logic [7:0] rdata_q, rdata_d;
  logic [6:0] r_q, r_d;
  logic       xpt_inc, xpt_clr;

  always_comb begin
    state_d  = state_q;
    itable_d = itable_q;
    rdata_d  = rdata_q;
    r_d      = r_q;
    xpt_inc  = 1'b0;
    xpt_clr  = 1'b0;
    unique case (state_q)
      ST_RST:   state_d = ST_M1_T1;
      ST_M1_T1: state_d = ST_M1_T2;
      ST_M1_T2: begin
        if (notWAIT) begin
          itable_d = DataIn;
          state_d  = ST_M1_T3;
        end
      end
      ST_M1_T3: state_d = ST_M1_T4;
      ST_M1_T4: begin
        if (RFSH_EN) begin
          r_d = r_q + 7'd1;
        end
        state_d = ST_DEC;
      end
      ST_MR_T1: state_d = ST_MR_T2;
      ST_MR_T2: begin
        if (notWAIT) begin
          rdata_d = DataIn;
          xpt_inc = 1'b1;
          state_d = ST_MR_T3;
        end
      end
      ST_MR_T3: state_d = ST_DEC;
      ST_DEC: begin
        // Decoder strobes are only meaningful while decode_enable is high.
        if (P2_Reset_ITABLE) begin
          itable_d = ITABLE_RESET;
        end
        xpt_clr = PR_Reset_XPT;
        if (P2_Set_CM1) begin
          state_d = ST_M1_T1;
        end else if (P2_Set_CMR) begin
          state_d = ST_MR_T1;
        end
      end
      default:  state_d = ST_RST;
    endcase
  end

  // pc_inc and data_valid are the one-cycle pulses that follow the T2 latch edge.
  always_comb begin
    MREQ          = 1'b0;
    RD            = 1'b0;
    M1            = 1'b0;
    RFSH          = 1'b0;
    addr_sel_r    = 1'b0;
    pc_inc        = 1'b0;
    data_valid    = 1'b0;
    decode_enable = 1'b0;
    unique case (state_q)
      ST_M1_T1, ST_M1_T2: begin
        MREQ = 1'b1;
        RD   = 1'b1;
        M1   = 1'b1;
      end
      ST_M1_T3, ST_M1_T4: begin
        MREQ       = RFSH_EN;
        RFSH       = RFSH_EN;
        addr_sel_r = RFSH_EN;
        pc_inc     = (state_q == ST_M1_T3);
      end
      ST_MR_T1, ST_MR_T2: begin
        MREQ = 1'b1;
        RD   = 1'b1;
      end
      ST_MR_T3: begin
        pc_inc     = 1'b1;
        data_valid = 1'b1;
      end
      ST_DEC:   decode_enable = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RST;
      itable_q <= ITABLE_RESET;
      rdata_q  <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      itable_q <= itable_d;
      rdata_q  <= rdata_d;
      r_q      <= r_d;
    end
  end

  norz_xpt_counter #(
    .MAX(XPT_MAX)
  ) u_xpt (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (xpt_clr),
    .inc_i  (xpt_inc),
    .cnt_o  (XPT),
    .cnt_n_o(notXPT)
  );

  assign ITABLE    = itable_q;
  assign notITABLE = ~itable_q;
  assign ReadData  = rdata_q;
  assign R         = r_q;

endmodule

// File: tb/tb_norz_cycle_sequencer.sv
// Directed-plus-random bench: per-cycle bus and register checks against a transaction-level model.
module tb_norz_cycle_sequencer;

  localparam int XPT_MAX = 15;
  localparam int PH_IDLE = 0, PH_M1A = 1, PH_M1T3 = 2, PH_M1T4 = 3,
                 PH_MRA = 4, PH_MRT3 = 5, PH_DEC = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] DataIn;
  logic       notWAIT, P2_Set_CM1, P2_Set_CMR, P2_Reset_ITABLE, PR_Reset_XPT;

  logic [7:0] ITABLE, notITABLE, ReadData;
  logic [3:0] XPT, notXPT;
  logic       decode_enable, MREQ, RD, M1, RFSH, addr_sel_r, pc_inc, data_valid;
  logic [6:0] R;

  logic [7:0] ITABLE0, notITABLE0, ReadData0;
  logic [3:0] XPT0, notXPT0;
  logic       decode_enable0, MREQ0, RD0, M10, RFSH0, addr_sel_r0, pc_inc0, data_valid0;
  logic [6:0] R0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_itab, m_rdata;
  int         m_xpt, m_r;

  always #5 clock = ~clock;

  norz_cycle_sequencer #(.RFSH_EN(1'b1), .XPT_MAX(XPT_MAX)) dut (
    .clock(clock), .reset(reset), .DataIn(DataIn), .notWAIT(notWAIT),
    .P2_Set_CM1(P2_Set_CM1), .P2_Set_CMR(P2_Set_CMR),
    .P2_Reset_ITABLE(P2_Reset_ITABLE), .PR_Reset_XPT(PR_Reset_XPT),
    .ITABLE(ITABLE), .notITABLE(notITABLE), .XPT(XPT), .notXPT(notXPT),
    .decode_enable(decode_enable), .MREQ(MREQ), .RD(RD), .M1(M1), .RFSH(RFSH),
    .addr_sel_r(addr_sel_r), .R(R), .pc_inc(pc_inc), .ReadData(ReadData),
    .data_valid(data_valid)
  );

  norz_cycle_sequencer #(.RFSH_EN(1'b0), .XPT_MAX(XPT_MAX)) dut0 (
    .clock(clock), .reset(reset), .DataIn(DataIn), .notWAIT(notWAIT),
    .P2_Set_CM1(P2_Set_CM1), .P2_Set_CMR(P2_Set_CMR),
    .P2_Reset_ITABLE(P2_Reset_ITABLE), .PR_Reset_XPT(PR_Reset_XPT),
    .ITABLE(ITABLE0), .notITABLE(notITABLE0), .XPT(XPT0), .notXPT(notXPT0),
    .decode_enable(decode_enable0), .MREQ(MREQ0), .RD(RD0), .M1(M10), .RFSH(RFSH0),
    .addr_sel_r(addr_sel_r0), .R(R0), .pc_inc(pc_inc0), .ReadData(ReadData0),
    .data_valid(data_valid0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_itab = 8'h00; m_rdata = 8'h00; m_xpt = 0; m_r = 0;
  endtask

  // Bus bits: {MREQ, RD, M1, RFSH, addr_sel_r, pc_inc, data_valid, decode_enable}
  task automatic check_all(input int ph, input string tag);
    logic [7:0] e1, e0;
    case (ph)
      PH_M1A:  begin e1 = 8'b1110_0000; e0 = 8'b1110_0000; end
      PH_M1T3: begin e1 = 8'b1001_1100; e0 = 8'b0000_0100; end
      PH_M1T4: begin e1 = 8'b1001_1000; e0 = 8'b0000_0000; end
      PH_MRA:  begin e1 = 8'b1100_0000; e0 = 8'b1100_0000; end
      PH_MRT3: begin e1 = 8'b0000_0110; e0 = 8'b0000_0110; end
      PH_DEC:  begin e1 = 8'b0000_0001; e0 = 8'b0000_0001; end
      default: begin e1 = 8'b0000_0000; e0 = 8'b0000_0000; end
    endcase
    chk({tag, ".bus"}, {MREQ, RD, M1, RFSH, addr_sel_r, pc_inc, data_valid, decode_enable}, e1);
    chk({tag, ".bus0"}, {MREQ0, RD0, M10, RFSH0, addr_sel_r0, pc_inc0, data_valid0, decode_enable0}, e0);
    chk({tag, ".ITABLE"}, ITABLE, m_itab);
    chk({tag, ".notITABLE"}, notITABLE, 8'hFF ^ m_itab);
    chk({tag, ".XPT"}, {4'h0, XPT}, 8'(m_xpt));
    chk({tag, ".notXPT"}, {4'h0, notXPT}, 8'(15 - m_xpt));
    chk({tag, ".R"}, {1'b0, R}, 8'(m_r));
    chk({tag, ".R0"}, {1'b0, R0}, 8'h00);
    chk({tag, ".ReadData"}, ReadData, m_rdata);
  endtask

  // Strobes and bus inputs outside DEC/T2 must have no effect.
  task automatic noise();
    {P2_Set_CM1, P2_Set_CMR, P2_Reset_ITABLE, PR_Reset_XPT} = 4'($urandom);
    notWAIT = 1'($urandom);
    DataIn  = 8'($urandom);
  endtask

  task automatic quiet();
    {P2_Set_CM1, P2_Set_CMR, P2_Reset_ITABLE, PR_Reset_XPT} = 4'b0000;
  endtask

  task automatic run_m1(input logic [7:0] op, input int waits, input bit from_rst,
                        input bit also_cmr, input bit r_it, input bit r_xpt, input string tag);
    if (from_rst) begin
      noise();
    end else begin
      P2_Set_CM1 = 1'b1; P2_Set_CMR = also_cmr;
      P2_Reset_ITABLE = r_it; PR_Reset_XPT = r_xpt;
      notWAIT = 1'($urandom); DataIn = 8'($urandom);
    end
    step();
    if (!from_rst && r_it)  m_itab = 8'h00;
    if (!from_rst && r_xpt) m_xpt = 0;
    check_all(PH_M1A, {tag, ".T1"});
    noise(); step();
    check_all(PH_M1A, {tag, ".T2"});
    for (int w = 0; w < waits; w++) begin
      noise(); notWAIT = 1'b0; step();
      check_all(PH_M1A, {tag, ".T2w"});
    end
    noise(); notWAIT = 1'b1; DataIn = op; step();
    m_itab = op;
    check_all(PH_M1T3, {tag, ".T3"});
    noise(); step();
    check_all(PH_M1T4, {tag, ".T4"});
    noise(); step();
    m_r = (m_r + 1) % 128;
    check_all(PH_DEC, {tag, ".DEC"});
    quiet();
  endtask

  task automatic run_mr(input logic [7:0] d, input int waits, input bit r_it,
                        input bit r_xpt, input string tag);
    P2_Set_CM1 = 1'b0; P2_Set_CMR = 1'b1;
    P2_Reset_ITABLE = r_it; PR_Reset_XPT = r_xpt;
    notWAIT = 1'($urandom); DataIn = 8'($urandom);
    step();
    if (r_it)  m_itab = 8'h00;
    if (r_xpt) m_xpt = 0;
    check_all(PH_MRA, {tag, ".T1"});
    noise(); step();
    check_all(PH_MRA, {tag, ".T2"});
    for (int w = 0; w < waits; w++) begin
      noise(); notWAIT = 1'b0; step();
      check_all(PH_MRA, {tag, ".T2w"});
    end
    noise(); notWAIT = 1'b1; DataIn = d; step();
    m_rdata = d;
    m_xpt = (m_xpt + 1 > XPT_MAX) ? XPT_MAX : m_xpt + 1;
    check_all(PH_MRT3, {tag, ".T3"});
    noise(); step();
    check_all(PH_DEC, {tag, ".DEC"});
    quiet();
  endtask

  task automatic idle_dec(input bit r_it, input bit r_xpt);
    P2_Set_CM1 = 1'b0; P2_Set_CMR = 1'b0;
    P2_Reset_ITABLE = r_it; PR_Reset_XPT = r_xpt;
    notWAIT = 1'($urandom); DataIn = 8'($urandom);
    step();
    if (r_it)  m_itab = 8'h00;
    if (r_xpt) m_xpt = 0;
    check_all(PH_DEC, "idle");
    quiet();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; DataIn = 8'h00; notWAIT = 1'b1;
    quiet();
    model_reset();
    #12;
    check_all(PH_IDLE, "reset");
    @(negedge clock); reset = 1'b0;

    run_m1(8'h01, 0, 1'b1, 1'b0, 1'b0, 1'b0, "first_m1");
    run_mr(8'h34, 0, 1'b0, 1'b0, "mr_34");
    run_mr(8'h12, 0, 1'b0, 1'b0, "mr_12");
    run_m1(8'hA5, 2, 1'b0, 1'b0, 1'b0, 1'b0, "m1_wait2");
    run_m1(8'h5A, 0, 1'b0, 1'b1, 1'b1, 1'b1, "m1_prio_clr");
    idle_dec(1'b0, 1'b0);
    idle_dec(1'b0, 1'b0);
    run_mr(8'hC3, 1, 1'b0, 1'b0, "mr_wait1");

    for (int i = 0; i < 40; i++) begin
      int  kind  = int'($urandom_range(0, 2));
      int  waits = int'($urandom_range(0, 3));
      bit  r_it  = ($urandom_range(0, 5) == 0);
      bit  r_xpt = ($urandom_range(0, 5) == 0);
      if (kind == 0)      run_m1(8'($urandom), waits, 1'b0, 1'($urandom), r_it, r_xpt, "rnd_m1");
      else if (kind == 1) run_mr(8'($urandom), waits, r_it, r_xpt, "rnd_mr");
      else                idle_dec(r_it, r_xpt);
    end

    for (int i = 0; i < 17; i++) begin
      run_mr(8'($urandom), 0, 1'b0, (i == 0), "sat_mr");
    end
    chk("sat.XPT", {4'h0, XPT}, 8'd15);
    chk("sat.notXPT", {4'h0, notXPT}, 8'd0);

    for (int i = 0; i < 128; i++) begin
      run_m1(8'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b0, "wrap_m1");
    end

    // Fresh start, then reset asynchronously while an MR is in T2 with notWAIT high.
    reset = 1'b1;
    #1;
    model_reset();
    check_all(PH_IDLE, "reset2");
    @(negedge clock); reset = 1'b0;
    run_m1(8'h77, 0, 1'b1, 1'b0, 1'b0, 1'b0, "m1_after_rst");
    P2_Set_CMR = 1'b1; step(); quiet();
    check_all(PH_MRA, "abort.T1");
    noise(); step();
    check_all(PH_MRA, "abort.T2");
    quiet(); notWAIT = 1'b1; DataIn = 8'hAB;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all(PH_IDLE, "abort.async");
    step();
    check_all(PH_IDLE, "abort.held");
    @(negedge clock); reset = 1'b0;
    run_m1(8'h3C, 1, 1'b1, 1'b0, 1'b0, 1'b0, "m1_recover");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/norz_cycle_sequencer.md
Name: norz_cycle_sequencer

Overview:
- Machine-cycle sequencer that produces the opcode-table and phase state consumed by the NORZ instruction decoder tree: ITABLE/notITABLE and XPT/notXPT.
- Consumes the decoder's cycle-request strobes (Set_CM1, Set_CMR, Reset_ITABLE, Reset_XPT).
- Runs the Z80-style bus cycles those strobes request: M1 opcode fetch with refresh, and memory read. Sits between the bus interface and the top-level decoder enable.

Parameters:
- RFSH_EN, 1, 1 = M1 T3/T4 drive refresh and advance R; 0 = T3/T4 idle, R frozen.
- XPT_MAX, 15, saturation value of the XPT phase counter (fits 4 bits).

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- DataIn  in  8  bus data, sampled in T2 of M1/MR when notWAIT=1.
- notWAIT  in  1  0 = extend T2 by one cycle.
- P2_Set_CM1  in  1  decoder strobe: next cycle is M1 opcode fetch.
- P2_Set_CMR  in  1  decoder strobe: next cycle is memory read.
- P2_Reset_ITABLE  in  1  decoder strobe: clear ITABLE.
- PR_Reset_XPT  in  1  decoder strobe: clear XPT.
- ITABLE  out  8  latched opcode.
- notITABLE  out  8  bitwise complement of ITABLE, always.
- XPT  out  4  execution phase counter.
- notXPT  out  4  bitwise complement of XPT, always.
- decode_enable  out  1  top-level enable into the decoder tree.
- MREQ  out  1  memory request.
- RD  out  1  read strobe.
- M1  out  1  opcode-fetch indicator.
- RFSH  out  1  refresh indicator.
- addr_sel_r  out  1  1 = address bus carries {I, R}; 0 = PC.
- R  out  7  refresh counter.
- pc_inc  out  1  one-cycle PC increment pulse.
- ReadData  out  8  data latched by the last MR cycle.
- data_valid  out  1  one-cycle pulse: ReadData is fresh (qualifies PR_Write_*).

Behaviour:
- Reset values: state RST; ITABLE=0x00, notITABLE=0xFF, XPT=0, notXPT=0xF, R=0, ReadData=0x00; all 1-bit outputs 0.
- All outputs are decoded from registers only. There is no combinational path from any input to any output.
- States: RST, M1_T1, M1_T2, M1_T3, M1_T4, MR_T1, MR_T2, MR_T3, DEC.
- RST: on the first edge after reset deasserts, go to M1_T1. Power-up always begins with an opcode fetch.
- M1_T1: MREQ=RD=M1=1, addr_sel_r=0. Go to M1_T2.
- M1_T2: MREQ=RD=M1=1.
  - notWAIT=0: stay in M1_T2.
  - notWAIT=1: at the edge, ITABLE<=DataIn, pc_inc=1 for the next cycle, go to M1_T3.
  - Each extra wait cycle adds exactly one cycle.
- M1_T3 and M1_T4: RD=M1=0.
  - RFSH_EN=1: MREQ=RFSH=addr_sel_r=1; R<=R+1 (mod 128) at the end of M1_T4.
  - RFSH_EN=0: all bus outputs 0.
  - M1_T4 goes to DEC.
- MR_T1: MREQ=RD=1, addr_sel_r=0. Go to MR_T2.
- MR_T2: same wait rule as M1_T2. On notWAIT=1: ReadData<=DataIn, pc_inc pulse, XPT<=min(XPT+1, XPT_MAX), go to MR_T3.
- MR_T3: bus idle, data_valid=1. Go to DEC.
- DEC: decode_enable=1. Strobes are honoured only while decode_enable=1 and are ignored in every other state.
  - P2_Set_CM1=1: go to M1_T1 (priority over P2_Set_CMR).
  - Else P2_Set_CMR=1: go to MR_T1.
  - Else: stay in DEC with decode_enable held at 1.
- P2_Reset_ITABLE in DEC: ITABLE<=0x00 at that edge, then reloaded by the following M1_T2.
- PR_Reset_XPT in DEC: XPT<=0 at that edge. Any later MR increment starts from 0.
- Complement outputs track their true outputs on the same edge. ITABLE XOR notITABLE is always 0xFF.
- Total latency: M1 = 4 cycles and MR = 3 cycles, plus wait cycles, plus one DEC cycle.
- Reset asserted mid-cycle: immediate return to RST values. No partial latch of DataIn.

Decomposition:
- Shared package norz_seq_pkg holds the state enum (9 states, 4-bit encoding) and the constants ITABLE_RESET=8'h00 and XPT_WIDTH=4.
- One sub-module, norz_xpt_counter: saturating 4-bit counter with clear, increment and true/complement outputs.
- The FSM, latches and R counter stay in the top module.

Test Plan:
- Reset, release, DataIn=0x01, notWAIT=1 -> ITABLE=0x01, notITABLE=0xFE after M1_T2; R=1 after M1_T4; decode_enable=1 on cycle 5.
- In DEC assert P2_Set_CMR twice with DataIn=0x34 then 0x12 -> ReadData=0x34 then 0x12, XPT=1 then 2, data_valid single pulse each, 3 cycles per MR.
- notWAIT=0 for 2 cycles in M1_T2 -> M1 lasts 6 cycles, ITABLE latched only on the notWAIT=1 edge, exactly one pc_inc.
- P2_Set_CM1 and P2_Set_CMR together with P2_Reset_ITABLE and PR_Reset_XPT in DEC -> M1 chosen, ITABLE=0x00 and XPT=0 on the next cycle, new opcode loaded at M1_T2.
- 17 consecutive MR cycles -> XPT saturates at 15, notXPT=0; R wraps 127 to 0 across 128 M1 cycles (RFSH_EN=1); with RFSH_EN=0, R stays 0 and RFSH never asserts.
- Reset asserted in MR_T2 with notWAIT=1 -> all outputs at reset values immediately; ReadData unchanged at 0x00.
